// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run sequencing, cycle/retire counting and stop detection for a multi-period CPU core
//
// Sequences the core's reset after a start pulse, counts RUN cycles and retired
// instructions (PC changes), and ends the run on a halt instruction, a stalled
// PC or an exhausted cycle budget. Compile-time option: define CPU_RUN_BREAK_EN
// to add a PC breakpoint that outranks every other exit.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset of this block
//   start             one-cycle pulse; honoured only in IDLE, HALTED, TIMEOUT
//   pc, inst          core program counter and current instruction
//   cpu_rst           reset driven to the core (high except in RUN)
//   running           high while in RUN
//   done, timeout     sticky end-of-run flags (halt/stall vs cycle budget)
//   cycle_count       RUN cycles elapsed, saturating
//   instr_count       retired instructions (PC changes), saturating
//   last_pc           PC captured on the exit cycle
//   bp_en, bp_addr    breakpoint enable and address (CPU_RUN_BREAK_EN only)
//   bp_hit            sticky, run ended on the breakpoint (CPU_RUN_BREAK_EN only)

module cpu_run_controller #(
    parameter int                   ADDR_W      = 32,
    parameter int                   INSTR_W     = 32,
    parameter int                   RST_CYCLES  = 1,
    parameter int                   MAX_CYCLES  = 70,
    parameter int                   STALL_LIMIT = 8,
    parameter logic [INSTR_W-1:0]   HALT_INST   = 32'hFFFF_FFFF,
    parameter int                   CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [INSTR_W-1:0]  inst,
`ifdef CPU_RUN_BREAK_EN
    input  logic                bp_en,
    input  logic [ADDR_W-1:0]   bp_addr,
    output logic                bp_hit,
`endif
    output logic                cpu_rst,
    output logic                running,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count,
    output logic [ADDR_W-1:0]   last_pc
);

    // Wide enough to hold STALL_LIMIT-1; the run exits before it could wrap.
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        RUN     = 3'd2,
        HALTED  = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [7:0]         rst_cnt, rst_cnt_d;
    logic [SW-1:0]      stall_cnt, stall_cnt_d;
    logic [ADDR_W-1:0]  prev_pc, prev_pc_d;
    logic               cpu_rst_d, running_d, done_d, timeout_d;
    logic [CNT_W-1:0]   cycle_count_d, instr_count_d;
    logic [ADDR_W-1:0]  last_pc_d;
    logic               bp_hit_q, bp_hit_d;

    logic               pc_changed;
    logic               halt_exit, stall_exit, time_exit, bp_exit;
    logic [CNT_W-1:0]   cyc_inc, ins_inc;

    assign pc_changed = (pc != prev_pc);
    assign cyc_inc    = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;
    assign ins_inc    = (instr_count == {CNT_W{1'b1}}) ? instr_count : instr_count + 1'b1;
    assign halt_exit  = (inst == HALT_INST);
    assign stall_exit = !pc_changed && (stall_cnt == SW'(STALL_LIMIT - 1));
    assign time_exit  = (cycle_count == CNT_W'(MAX_CYCLES - 1));

`ifdef CPU_RUN_BREAK_EN
    assign bp_exit = bp_en && (pc == bp_addr);
    assign bp_hit  = bp_hit_q;
`else
    assign bp_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            last_pc     <= '0;
            bp_hit_q    <= 1'b0;
        end else begin
            state       <= state_d;
            rst_cnt     <= rst_cnt_d;
            stall_cnt   <= stall_cnt_d;
            prev_pc     <= prev_pc_d;
            cpu_rst     <= cpu_rst_d;
            running     <= running_d;
            done        <= done_d;
            timeout     <= timeout_d;
            cycle_count <= cycle_count_d;
            instr_count <= instr_count_d;
            last_pc     <= last_pc_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    always_comb begin
        state_d       = state;
        rst_cnt_d     = rst_cnt;
        stall_cnt_d   = stall_cnt;
        prev_pc_d     = prev_pc;
        cpu_rst_d     = cpu_rst;
        running_d     = running;
        done_d        = done;
        timeout_d     = timeout;
        cycle_count_d = cycle_count;
        instr_count_d = instr_count;
        last_pc_d     = last_pc;
        bp_hit_d      = bp_hit_q;

        case (state)
            IDLE, HALTED, TIMEOUT: begin
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
                if (start) begin
                    state_d       = RESET;
                    rst_cnt_d     = 8'(RST_CYCLES);
                    cycle_count_d = '0;
                    instr_count_d = '0;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    bp_hit_d      = 1'b0;
                end
            end

            RESET: begin
                cpu_rst_d = 1'b1;
                if (rst_cnt <= 8'd1) begin
                    // Last reset cycle: release the core and snapshot its PC so
                    // the first RUN cycle compares against the reset vector.
                    state_d     = RUN;
                    cpu_rst_d   = 1'b0;
                    running_d   = 1'b1;
                    prev_pc_d   = pc;
                    stall_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt - 8'd1;
                end
            end

            RUN: begin
                cycle_count_d = cyc_inc;
                if (pc_changed) begin
                    instr_count_d = ins_inc;
                    stall_cnt_d   = '0;
                    prev_pc_d     = pc;
                end else begin
                    stall_cnt_d = stall_cnt + 1'b1;
                end

                if (bp_exit || halt_exit || stall_exit || time_exit) begin
                    cpu_rst_d = 1'b1;
                    running_d = 1'b0;
                    last_pc_d = pc;
                end

                if (bp_exit) begin
                    state_d  = HALTED;
                    done_d   = 1'b1;
                    bp_hit_d = 1'b1;
`ifdef CPU_RUN_BREAK_EN
                    last_pc_d = bp_addr;
`endif
                end else if (halt_exit || stall_exit) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else if (time_exit) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller

module tb_cpu_run_controller;

    localparam int          AW   = 32;
    localparam int          IW   = 32;
    localparam int          RSTC = 3;
    localparam int          MAXC = 70;
    localparam int          STL  = 8;
    localparam int          CW   = 16;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  pc;
    logic [IW-1:0]  inst;
    logic           cpu_rst, running, done, timeout;
    logic [CW-1:0]  cycle_count, instr_count;
    logic [AW-1:0]  last_pc;
`ifdef CPU_RUN_BREAK_EN
    logic           bp_en;
    logic [AW-1:0]  bp_addr;
    logic           bp_hit;
`endif

    cpu_run_controller #(
        .ADDR_W(AW), .INSTR_W(IW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .STALL_LIMIT(STL), .HALT_INST(HALT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .inst(inst),
`ifdef CPU_RUN_BREAK_EN
        .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
        .cpu_rst(cpu_rst), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .instr_count(instr_count), .last_pc(last_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic        timeout;
        logic        bp;
        logic [15:0] cyc;
        logic [15:0] ins;
        logic [31:0] lpc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ppc[$];
    logic [31:0] pinst[$];
    logic        pbp_en   = 1'b0;
    logic [31:0] pbp_addr = '0;
    int          checks   = 0;
    int          failures = 0;
    logic        mon_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: walk the per-cycle program and apply the exit rules directly.
    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] prev = ppc[0];
        int          same_run = 0;
        int          ins = 0;
        e = '0;
        for (int i = 0; i < ppc.size(); i++) begin
            bit changed = (ppc[i] != prev);
            bit bp, hlt, stl, tmo;
            if (changed) begin
                ins++;
                same_run = 0;
            end else begin
                same_run++;
            end
            prev = ppc[i];
            bp  = pbp_en && (ppc[i] == pbp_addr);
            hlt = (pinst[i] == HALT);
            stl = !changed && (same_run == STL);
            tmo = (i == MAXC - 1);
            if (bp || hlt || stl || tmo) begin
                e.done    = bp || hlt || stl;
                e.timeout = !(bp || hlt || stl);
                e.bp      = bp;
                e.cyc     = 16'(i + 1);
                e.ins     = 16'(ins);
                e.lpc     = bp ? pbp_addr : ppc[i];
                return e;
            end
        end
        return e;
    endfunction

    task automatic add_steps(input logic [31:0] first, input int step, input int cpi, input int n);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < cpi; c++) begin
                ppc.push_back(first + 32'(k * step));
                pinst.push_back(32'h0000_0013);
            end
    endtask

    task automatic gen_random();
        logic [31:0] p;
        int          halt_i;
        p = 32'($urandom_range(0, 255) * 4);
        halt_i = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 79) : -1;
        ppc.delete();
        pinst.delete();
        while (ppc.size() < 80) begin
            int hold;
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 5);
            for (int k = 0; k < hold && ppc.size() < 80; k++) begin
                ppc.push_back(p);
                pinst.push_back($urandom() & 32'h7FFF_FFFF);
            end
            p = p + 32'(4 * $urandom_range(1, 3));
        end
        if (halt_i >= 0) pinst[halt_i] = HALT;
    endtask

    task automatic start_run();
        int n = 0;
        int rc = 0;
        pc   = ppc[0];
        inst = 32'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_timeout", timeout, 0);
        chk("clr_cycles", cycle_count, 0);
        chk("clr_instr", instr_count, 0);
        while (!running && n < 40) begin
            if (cpu_rst) rc++;
            @(negedge clk);
            n++;
        end
        chk("reset_hold_cycles", rc, RSTC);
        chk("run_entered", running, 1);
        chk("run_cpu_rst_low", cpu_rst, 0);
        chk("run_first_count", cycle_count, 0);
    endtask

    task automatic run_prog();
        int i = 0;
        sb.push_back(predict());
        start_run();
        while (i < ppc.size()) begin
            pc   = ppc[i];
            inst = pinst[i];
            @(negedge clk);
            i++;
            if (!running) break;
        end
        chk("run_ended", running, 0);
        inst = 32'h0;
        @(negedge clk);
    endtask

    // Monitor: each rising end-of-run flag retires one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if ((done || timeout) && !mon_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_run_end", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_done", done, e.done);
                    chk("sb_timeout", timeout, e.timeout);
                    chk("sb_cycle_count", cycle_count, e.cyc);
                    chk("sb_instr_count", instr_count, e.ins);
                    chk("sb_last_pc", last_pc, e.lpc);
                    chk("sb_cpu_rst_after_exit", cpu_rst, 1);
                    chk("sb_running_after_exit", running, 0);
`ifdef CPU_RUN_BREAK_EN
                    chk("sb_bp_hit", bp_hit, e.bp);
`endif
                end
            end
            mon_prev = done || timeout;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pc    = '0;
        inst  = '0;
`ifdef CPU_RUN_BREAK_EN
        bp_en   = 1'b0;
        bp_addr = '0;
`endif
        #12;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_instr", instr_count, 0);
        chk("rst_last_pc", last_pc, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_cpu_rst", cpu_rst, 1);

        // Halt instruction after three 4-cycle instructions.
        ppc.delete(); pinst.delete();
        add_steps(32'h0, 4, 4, 3);
        ppc.push_back(32'hC); pinst.push_back(HALT);
        run_prog();

        // PC stuck at 0x20 from RUN entry.
        ppc.delete(); pinst.delete();
        add_steps(32'h20, 0, 1, 20);
        run_prog();

        // Budget exhausted, PC advancing every 3 cycles.
        ppc.delete(); pinst.delete();
        add_steps(32'h100, 4, 3, 30);
        run_prog();

        // Halt on the same cycle the budget runs out.
        ppc.delete(); pinst.delete();
        add_steps(32'h100, 4, 3, 30);
        pinst[MAXC - 1] = HALT;
        run_prog();

        // Mid-run reset: outputs must react before the next clock edge.
        ppc.delete(); pinst.delete();
        add_steps(32'h40, 4, 2, 10);
        start_run();
        for (int k = 0; k < 5; k++) begin
            pc = ppc[k]; inst = pinst[k];
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cpu_rst", cpu_rst, 1);
        chk("async_rst_running", running, 0);
        chk("async_rst_cycles", cycle_count, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

`ifdef CPU_RUN_BREAK_EN
        ppc.delete(); pinst.delete();
        add_steps(32'h0, 4, 2, 4);
        ppc.push_back(32'h10); pinst.push_back(HALT);
        pbp_en = 1'b1; pbp_addr = 32'h10;
        bp_en = 1'b1; bp_addr = 32'h10;
        run_prog();
        pbp_en = 1'b0; bp_en = 1'b0;
        run_prog();
`endif

        for (int r = 0; r < 20; r++) begin
            gen_random();
            run_prog();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Synthesisable run controller placed alongside a multi-period CPU core. It sequences the core's reset, counts elapsed cycles and retired instructions, and stops the run on one of three events: a halt instruction, a stalled PC, or a cycle budget being exhausted. It replaces fixed-delay reset/finish sequencing with parametrised, observable run control that both simulation and FPGA bring-up can use.

Parameters:
ADDR_W, 32, PC width; matches `ADDR_LEN
INSTR_W, 32, instruction width; matches `INSTR_LEN
RST_CYCLES, 1, cycles cpu_rst is held high after start; legal range 1..255
MAX_CYCLES, 70, RUN-state cycle budget before timeout; must be >= 1
STALL_LIMIT, 8, consecutive RUN cycles with an unchanged PC that declare a halt; must exceed the core's maximum CPI
HALT_INST, 32'hFFFF_FFFF, instruction encoding that ends the run
CNT_W, 16, width of the cycle and instruction counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset of this block
start  in  1  one-cycle pulse that begins a run; ignored unless the state is IDLE or a terminal state
pc  in  ADDR_W  core program counter
inst  in  INSTR_W  core instruction being executed
cpu_rst  out  1  reset driven to the core
running  out  1  high in the RUN state
done  out  1  sticky; run ended by halt instruction or PC stall
timeout  out  1  sticky; run ended by the cycle budget
cycle_count  out  CNT_W  RUN cycles elapsed
instr_count  out  CNT_W  retired instructions (PC changes)
last_pc  out  ADDR_W  PC captured when the run ended

Behaviour:
- Reset of this block (asynchronous, active-high):
  - state = IDLE.
  - cpu_rst = 1, so the core stays in reset while idle.
  - running, done and timeout = 0.
  - cycle_count, instr_count and last_pc = 0.
- FSM states: IDLE, RESET, RUN, HALTED, TIMEOUT.
- IDLE:
  - cpu_rst = 1.
  - On start: go to RESET, load the reset counter with RST_CYCLES, clear all counters and the sticky flags.
- RESET:
  - cpu_rst = 1 for exactly RST_CYCLES cycles.
  - Then go to RUN; cpu_rst = 0 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones.
  - Retirement:
    - A registered previous-PC register is loaded on RUN entry.
    - When pc != previous PC, instr_count increments (saturating) and the stall counter clears.
    - Otherwise the stall counter increments.
- RUN exits, evaluated each cycle in this priority order:
  1. inst == HALT_INST → HALTED.
  2. stall counter reaches STALL_LIMIT-1 while the PC is unchanged → HALTED.
  3. cycle_count reaches MAX_CYCLES-1 → TIMEOUT.
  - If several conditions are true in the same cycle, the highest-priority one wins.
  - The exit cycle itself is still counted in cycle_count.
- On every RUN exit:
  - last_pc <= pc.
  - cpu_rst <= 1 on the next cycle, which freezes the core.
  - running <= 0.
- HALTED: done = 1, held.
- TIMEOUT: timeout = 1, held.
- Terminal states:
  - Counters and last_pc hold their values.
  - start re-arms the run: go to RESET and clear the flags and counters.
- start is ignored in the RESET and RUN states.
- All outputs are registered; no combinational path from input to output.
- rst asserted mid-run forces IDLE immediately. cpu_rst rises asynchronously with it.

Optional Feature:
CPU_RUN_BREAK_EN
- Enabled:
  - Adds inputs bp_en (1 bit) and bp_addr (ADDR_W), plus output bp_hit (1 bit, sticky, reset 0).
  - In RUN, pc == bp_addr with bp_en = 1 is a new exit condition at priority 0, above the halt instruction.
  - On that exit: go to HALTED, set done = 1 and bp_hit = 1, capture last_pc = bp_addr.
  - bp_hit clears on start.
- Disabled: none of these ports exist, and behaviour is exactly as above.

Test Plan:
1. Reset release with RST_CYCLES=3:
   - Stimulus: start pulse.
   - Required: cpu_rst stays high 3 cycles after start, then running = 1 and cycle_count counts up from 0 with cpu_rst = 0.
2. Halt instruction:
   - Stimulus: PC steps 0,4,8 with 4 cycles per instruction, then inst = FFFF_FFFF at pc = 0xC.
   - Required: done = 1, instr_count = 3, last_pc = 0xC, cpu_rst = 1 on the next cycle.
3. PC stall with STALL_LIMIT=8:
   - Stimulus: PC held at 0x20 from RUN entry.
   - Required: HALTED on the 8th RUN cycle, instr_count = 0, last_pc = 0x20.
4. Timeout with MAX_CYCLES=70:
   - Stimulus: PC advancing every 3 cycles.
   - Required: timeout = 1 with cycle_count = 70 and done = 0.
   - Then a start pulse clears all flags and counters and a new run begins.
5. Simultaneous exits and mid-run reset:
   - Stimulus: halt instruction on the same cycle cycle_count reaches 69.
   - Required: done = 1 and timeout = 0.
   - Then asserting rst mid-run drops running to 0 and forces cpu_rst = 1 without waiting for a clock edge.
6. With CPU_RUN_BREAK_EN:
   - Stimulus: bp_addr = 0x10, bp_en = 1, and the halt instruction also at pc = 0x10.
   - Required: bp_hit = 1, done = 1, last_pc = 0x10.
   - Repeat with bp_en = 0: the breakpoint is ignored and the run ends on the halt instruction with bp_hit = 0.
